// File: rtl/sort_stream_checker_pkg.sv
// Shared types for the sort stream checker: FSM states, report record and LFSR constants.
package sort_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    FLUSH
  } chk_state_e;

  // Report length field is sized for the default MAX_PKT_LEN; the checker casts to its own LWIDTH.
  localparam int RPT_LEN_W = 9;

  typedef struct packed {
    logic [RPT_LEN_W-1:0] len;
    logic                 order;
    logic                 frame;
    logic                 lenerr;
  } rpt_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sort_stream_checker_lfsr_throttle.sv
// Pseudo-random ready generator (~75% duty); only compiled when READY_THROTTLE_EN is defined.
`ifdef READY_THROTTLE_EN
module lfsr_throttle
  import sort_chk_pkg::*;
(
  input  logic clk_i,
  input  logic arst_n_i,
  output logic ready_o
);

  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting feedback into bit 0.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign ready_o = (lfsr_q[1:0] != 2'b00);

endmodule
`endif

// File: rtl/sort_stream_checker.sv
// Avalon-ST sink checking sop/eop framing, non-decreasing order and packet length.
// Define READY_THROTTLE_EN to add LFSR-driven backpressure on snk_ready_o.
module sort_stream_checker
  import sort_chk_pkg::*;
#(
  parameter int DWIDTH      = 16,
  parameter int MAX_PKT_LEN = 250,
  parameter int CNT_W       = 16,
  localparam int LWIDTH     = $clog2(MAX_PKT_LEN + 1) + 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic              rpt_valid_o,
  output logic [LWIDTH-1:0] rpt_len_o,
  output logic              rpt_ok_o,
  output logic              rpt_err_order_o,
  output logic              rpt_err_frame_o,
  output logic              rpt_err_len_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam logic [LWIDTH-1:0] MAX_LEN = LWIDTH'(MAX_PKT_LEN);
  localparam logic [LWIDTH-1:0] ONE_LEN = LWIDTH'(1);

  chk_state_e        state_q, state_d;
  logic [LWIDTH-1:0] len_q, len_inc;
  logic [DWIDTH-1:0] prev_q;
  logic              order_q, order_hit;
  logic              ready_q, throttle_rdy, beat;
  logic              fire, orphan, ok_d, rpt_valid_q;
  rpt_t              rpt_q, rpt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, err_cnt_q;
  logic [CNT_W:0]    pkt_sum, err_sum;
  logic [1:0]        err_inc;

  function automatic rpt_t mk_rpt(input logic [LWIDTH-1:0] len, input logic order,
                                  input logic frame);
    rpt_t r;
    r.len    = RPT_LEN_W'(len);
    r.order  = order;
    r.frame  = frame;
    r.lenerr = (len > MAX_LEN);
    return r;
  endfunction

`ifdef READY_THROTTLE_EN
  lfsr_throttle u_throttle (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .ready_o  (throttle_rdy)
  );
`else
  assign throttle_rdy = 1'b1;
`endif

  assign snk_ready_o = ready_q & throttle_rdy;
  assign beat        = snk_valid_i & snk_ready_o;
  assign len_inc     = (len_q == '1) ? len_q : len_q + ONE_LEN;
  assign order_hit   = (snk_data_i < prev_q);

  // Decode which report (if any) the current beat closes and where the FSM goes next.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    orphan  = 1'b0;
    rpt_d   = rpt_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          if (snk_startofpacket_i && snk_endofpacket_i) begin
            fire  = 1'b1;
            rpt_d = mk_rpt(ONE_LEN, 1'b0, 1'b0);
          end else if (snk_startofpacket_i) begin
            state_d = IN_PKT;
          end else begin
            orphan = 1'b1;
          end
        end
      end
      IN_PKT: begin
        if (beat) begin
          if (snk_startofpacket_i) begin
            fire  = 1'b1;
            rpt_d = mk_rpt(len_q, order_q, 1'b1);
            if (snk_endofpacket_i) state_d = FLUSH;
          end else if (snk_endofpacket_i) begin
            fire    = 1'b1;
            rpt_d   = mk_rpt(len_inc, order_q | order_hit, 1'b0);
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        fire    = 1'b1;
        rpt_d   = mk_rpt(ONE_LEN, 1'b0, 1'b0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ok_d    = !(rpt_d.order | rpt_d.frame | rpt_d.lenerr);
  assign err_inc = {1'b0, orphan} + {1'b0, fire & ~ok_d};
  assign pkt_sum = {1'b0, pkt_cnt_q} + (CNT_W + 1)'(fire);
  assign err_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_inc);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      prev_q      <= '0;
      order_q     <= 1'b0;
      ready_q     <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_q       <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d != FLUSH);
      rpt_valid_q <= fire;
      if (fire) rpt_q <= rpt_d;
      pkt_cnt_q   <= pkt_sum[CNT_W] ? '1 : pkt_sum[CNT_W-1:0];
      err_cnt_q   <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      // Every accepted sop restarts tracking, so stray updates from orphan beats are harmless.
      if (beat) begin
        if (snk_startofpacket_i) begin
          len_q   <= ONE_LEN;
          order_q <= 1'b0;
        end else begin
          len_q   <= len_inc;
          order_q <= order_q | order_hit;
        end
        prev_q <= snk_data_i;
      end
    end
  end

  assign rpt_valid_o     = rpt_valid_q;
  assign rpt_len_o       = LWIDTH'(rpt_q.len);
  assign rpt_err_order_o = rpt_q.order;
  assign rpt_err_frame_o = rpt_q.frame;
  assign rpt_err_len_o   = rpt_q.lenerr;
  assign rpt_ok_o        = rpt_valid_q | (|rpt_q) ? !(rpt_q.order | rpt_q.frame | rpt_q.lenerr) & (|rpt_q.len) : 1'b0;
  assign pkt_cnt_o       = pkt_cnt_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_sort_stream_checker.sv
// Scoreboard bench for sort_stream_checker: a behavioural model pushes expected reports on each
// accepted beat; a negedge monitor pops and compares them when rpt_valid_o pulses.
module tb_sort_stream_checker;

  localparam int DWIDTH      = 16;
  localparam int MAX_PKT_LEN = 250;
  localparam int CNT_W       = 16;
  localparam int LWIDTH      = $clog2(MAX_PKT_LEN + 1) + 1;

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic [DWIDTH-1:0] snk_data_i;
  logic              snk_startofpacket_i;
  logic              snk_endofpacket_i;
  logic              snk_valid_i;
  logic              snk_ready_o;
  logic              rpt_valid_o;
  logic [LWIDTH-1:0] rpt_len_o;
  logic              rpt_ok_o;
  logic              rpt_err_order_o;
  logic              rpt_err_frame_o;
  logic              rpt_err_len_o;
  logic [CNT_W-1:0]  pkt_cnt_o;
  logic [CNT_W-1:0]  err_cnt_o;

  sort_stream_checker #(
    .DWIDTH      (DWIDTH),
    .MAX_PKT_LEN (MAX_PKT_LEN),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i               (clk_i),
    .arst_n_i            (arst_n_i),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .rpt_valid_o         (rpt_valid_o),
    .rpt_len_o           (rpt_len_o),
    .rpt_ok_o            (rpt_ok_o),
    .rpt_err_order_o     (rpt_err_order_o),
    .rpt_err_frame_o     (rpt_err_frame_o),
    .rpt_err_len_o       (rpt_err_len_o),
    .pkt_cnt_o           (pkt_cnt_o),
    .err_cnt_o           (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int len;
    int ok;
    int order;
    int frame;
    int lenerr;
    int pkt;
    int err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  bit m_in_pkt;
  int m_len, m_prev, m_pkt, m_err;
  bit m_order;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic push_report(input int len, input bit order, input bit frame);
    exp_t e;
    e.len    = len;
    e.order  = order;
    e.frame  = frame;
    e.lenerr = (len > MAX_PKT_LEN);
    e.ok     = !(e.order || e.frame || e.lenerr);
    if (m_pkt < 65535) m_pkt++;
    if (!e.ok && m_err < 65535) m_err++;
    e.pkt = m_pkt;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Reference behaviour for one accepted beat.
  task automatic model_beat(input int d, input bit sop, input bit eop);
    if (!m_in_pkt) begin
      if (sop && eop) push_report(1, 0, 0);
      else if (sop) begin
        m_in_pkt = 1; m_len = 1; m_prev = d; m_order = 0;
      end else if (m_err < 65535) m_err++;
    end else if (sop) begin
      push_report(m_len, m_order, 1);
      if (eop) begin
        push_report(1, 0, 0);
        m_in_pkt = 0;
      end else begin
        m_len = 1; m_prev = d; m_order = 0;
      end
    end else begin
      if (m_len < 511) m_len++;
      if (d < m_prev) m_order = 1;
      m_prev = d;
      if (eop) begin
        push_report(m_len, m_order, 0);
        m_in_pkt = 0;
      end
    end
  endtask

  // Holds the beat on the bus until the DUT accepts it; called and returns at posedge+1.
  task automatic applyStimulus(input int d, input bit sop, input bit eop);
    bit rdy;
    int waits = 0;
    snk_data_i          = DWIDTH'(d);
    snk_startofpacket_i = sop;
    snk_endofpacket_i   = eop;
    snk_valid_i         = 1'b1;
    forever begin
      @(negedge clk_i);
      rdy = snk_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) begin
        model_beat(d, sop, eop);
        break;
      end
      waits++;
      if (waits > 200) begin
        checkOutput("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    snk_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input int vals[$]);
    foreach (vals[i]) applyStimulus(vals[i], i == 0, i == vals.size() - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  always @(negedge clk_i) begin
    if (arst_n_i && rpt_valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_report", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rpt_len", 32'(rpt_len_o), mon_e.len);
        checkOutput("rpt_ok", 32'(rpt_ok_o), mon_e.ok);
        checkOutput("rpt_err_order", 32'(rpt_err_order_o), mon_e.order);
        checkOutput("rpt_err_frame", 32'(rpt_err_frame_o), mon_e.frame);
        checkOutput("rpt_err_len", 32'(rpt_err_len_o), mon_e.lenerr);
        checkOutput("pkt_cnt", 32'(pkt_cnt_o), mon_e.pkt);
        checkOutput("err_cnt", 32'(err_cnt_o), mon_e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vals[$];
    int v;
    int npkts;
    arst_n_i            = 1'b0;
    snk_data_i          = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
    snk_valid_i         = 1'b0;
    m_in_pkt = 0; m_pkt = 0; m_err = 0; m_len = 0; m_prev = 0; m_order = 0;

    repeat (3) @(negedge clk_i);
    checkOutput("reset_ready", 32'(snk_ready_o), 32'd0);
    checkOutput("reset_rpt_valid", 32'(rpt_valid_o), 32'd0);
    checkOutput("reset_rpt_len", 32'(rpt_len_o), 32'd0);
    checkOutput("reset_rpt_ok", 32'(rpt_ok_o), 32'd0);
    checkOutput("reset_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt_o), 32'd0);
    arst_n_i = 1'b1;
    @(negedge clk_i);
`ifndef READY_THROTTLE_EN
    checkOutput("ready_after_reset", 32'(snk_ready_o), 32'd1);
`endif
    @(posedge clk_i);
    #1;

    $display("[TB] sorted packet, equal neighbours");
    send_pkt('{1, 2, 2, 5, 9});
    idle(2);

    $display("[TB] order violation");
    send_pkt('{3, 7, 4, 8});
    idle(2);

    $display("[TB] sop abort followed by single-beat packet");
    applyStimulus(1, 1, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(6, 1, 1);
    @(negedge clk_i);
    checkOutput("flush_ready_low", 32'(snk_ready_o), 32'd0);
    @(negedge clk_i);
`ifndef READY_THROTTLE_EN
    checkOutput("ready_after_flush", 32'(snk_ready_o), 32'd1);
`endif
    @(posedge clk_i);
    #1;
    idle(2);

    $display("[TB] length boundary 251 and 250");
    vals.delete();
    for (int i = 0; i < 251; i++) vals.push_back(i);
    send_pkt(vals);
    idle(2);
    void'(vals.pop_back());
    send_pkt(vals);
    idle(2);

    $display("[TB] orphan beat in idle");
    applyStimulus(7, 0, 0);
    @(negedge clk_i);
    checkOutput("orphan_err_cnt", 32'(err_cnt_o), m_err);
    checkOutput("orphan_pkt_cnt", 32'(pkt_cnt_o), m_pkt);
    @(posedge clk_i);
    #1;

    $display("[TB] reset mid-packet");
    applyStimulus(10, 1, 0);
    applyStimulus(11, 0, 0);
    arst_n_i = 1'b0;
    #2;
    checkOutput("midrst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    checkOutput("midrst_err_cnt", 32'(err_cnt_o), 32'd0);
    checkOutput("midrst_rpt_valid", 32'(rpt_valid_o), 32'd0);
    checkOutput("midrst_pending", 32'(exp_q.size()), 32'd0);
    m_in_pkt = 0; m_pkt = 0; m_err = 0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    idle(4);
    send_pkt('{4, 5});
    idle(2);

`ifdef READY_THROTTLE_EN
    npkts = 100;
`else
    npkts = 20;
`endif
    $display("[TB] %0d random sorted packets", npkts);
    for (int p = 0; p < npkts; p++) begin
      vals.delete();
      v = int'($urandom_range(0, 1000));
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        vals.push_back(v);
        v += int'($urandom_range(0, 3));
      end
      send_pkt(vals);
      idle(int'($urandom_range(0, 2)));
    end

    idle(5);
    checkOutput("reports_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("final_pkt_cnt", 32'(pkt_cnt_o), m_pkt);
    checkOutput("final_err_cnt", 32'(err_cnt_o), m_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
